// File: rtl/speed_tick_gen_if.sv
// Button and tick bundle between the speed buttons, the tick generator and the
// colour-cycling lights stage.
interface speed_tick_gen_if;
   logic       speed1;
   logic       speed2;
   logic       speed3;
   logic       tick;
   logic       div_clk;
   logic [1:0] speed_sel;

   modport master (
      output speed1, speed2, speed3,
      input  tick, div_clk, speed_sel
   );

   modport slave (
      input  speed1, speed2, speed3,
      output tick, div_clk, speed_sel
   );
endinterface

// File: rtl/speed_tick_gen.sv
// Debounces three speed buttons, latches the most recent press and divides clk
// into a one-cycle tick plus a 50% duty div_clk at the selected period.
module speed_tick_gen #(
   parameter int DEB_CYCLES = 500000,
   parameter int P0         = 50000000,
   parameter int P1         = 25000000,
   parameter int P2         = 12500000,
   parameter int P3         = 5000000
) (
   input logic              clk,
   input logic              reset,
   speed_tick_gen_if.slave  bus
);
   localparam int P01  = (P0 > P1) ? P0 : P1;
   localparam int P23  = (P2 > P3) ? P2 : P3;
   localparam int PMAX = (P01 > P23) ? P01 : P23;
   localparam int CW   = $clog2(PMAX);
   localparam int DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0] P0_LAST  = CW'(P0 - 1);
   localparam logic [CW-1:0] P1_LAST  = CW'(P1 - 1);
   localparam logic [CW-1:0] P2_LAST  = CW'(P2 - 1);
   localparam logic [CW-1:0] P3_LAST  = CW'(P3 - 1);

   logic [2:0]    raw;
   logic [2:0]    sync1;
   logic [2:0]    sync2;
   logic [2:0]    deb;
   logic [2:0]    deb_q;
   logic [2:0]    press;
   logic [DW-1:0] dc [3];
   logic [CW-1:0] div_cnt;
   logic [CW-1:0] per_last;
   logic [1:0]    sel_r;
   logic [1:0]    new_sel;
   logic          tick_r;
   logic          div_clk_r;

   assign raw   = {bus.speed3, bus.speed2, bus.speed1};
   assign press = deb & ~deb_q;

   assign bus.tick      = tick_r;
   assign bus.div_clk   = div_clk_r;
   assign bus.speed_sel = sel_r;

   always_comb begin
      per_last = P0_LAST;
      case (sel_r)
         2'd1:    per_last = P1_LAST;
         2'd2:    per_last = P2_LAST;
         2'd3:    per_last = P3_LAST;
         default: per_last = P0_LAST;
      endcase
   end

   // Highest-numbered button wins when presses land on the same edge.
   always_comb begin
      new_sel = sel_r;
      if (press[2])      new_sel = 2'd3;
      else if (press[1]) new_sel = 2'd2;
      else if (press[0]) new_sel = 2'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1     <= '0;
         sync2     <= '0;
         deb       <= '0;
         deb_q     <= '0;
         for (int i = 0; i < 3; i++) dc[i] <= '0;
         div_cnt   <= '0;
         sel_r     <= 2'd0;
         tick_r    <= 1'b0;
         div_clk_r <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         deb_q <= deb;

         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == deb[i]) begin
               dc[i] <= '0;
            end else if (dc[i] == DEB_LAST) begin
               deb[i] <= sync2[i];
               dc[i]  <= '0;
            end else begin
               dc[i] <= dc[i] + DW'(1);
            end
         end

         // A press restarts the period and swallows any wrap due on this edge.
         if (|press) begin
            sel_r   <= new_sel;
            div_cnt <= '0;
            tick_r  <= 1'b0;
         end else if (div_cnt == per_last) begin
            div_cnt   <= '0;
            tick_r    <= 1'b1;
            div_clk_r <= ~div_clk_r;
         end else begin
            div_cnt <= div_cnt + CW'(1);
            tick_r  <= 1'b0;
         end
      end
   end
endmodule

// File: doc/speed_tick_gen.md
# speed_tick_gen

Clock-enable generator that turns three raw speed push-buttons into a paced tick stream for the light-sequencing stage. It synchronises and debounces `speed1`/`speed2`/`speed3`, latches the most recently pressed speed, and divides `clk` down to the selected rate. Outputs are a one-cycle `tick` enable and a 50 % duty `div_clk`. It sits directly upstream of the colour-cycling lights block, which advances one colour per tick or per `div_clk` rising edge.

## Interface
- `DEB_CYCLES`, default 500000: consecutive stable cycles required before a debounced input changes; must be ≥1.
- `P0`, default 50000000: tick period in `clk` cycles when no speed has been selected; must be ≥2.
- `P1`, default 25000000: tick period after a `speed1` press; must be ≥2.
- `P2`, default 12500000: tick period after a `speed2` press; must be ≥2.
- `P3`, default 5000000: tick period after a `speed3` press; must be ≥2.
- `clk` input 1: single system clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high; all registers clear on the first `clk` edge where it is high.
- `speed1` input 1: raw, asynchronous, bouncy button, active-high.
- `speed2` input 1: same as `speed1`.
- `speed3` input 1: same as `speed1`.
- `tick` output 1: high for exactly one cycle per period.
- `div_clk` output 1: toggles on every edge that raises `tick`.
- `speed_sel` output 2: currently latched speed, 0 = default/P0, 1..3 = P1..P3.

## Operation
- **Synchroniser:** each button passes through a 2-flop chain. The second flop output is `s_n`.
- **Debounce (per button):** uses counter `dc_n` and debounced level `deb_n`.
  - If `s_n == deb_n`: `dc_n <= 0`.
  - Else if `dc_n == DEB_CYCLES-1`: `deb_n <= s_n` and `dc_n <= 0`.
  - Else: `dc_n <= dc_n+1`.
  - Any glitch shorter than `DEB_CYCLES` cycles is discarded.
- **Press detect:** register `deb_q_n <= deb_n`. A press is `deb_n & ~deb_q_n`. Releases are ignored.
- **Selection:** `speed_sel` is sticky.
  - On a press it becomes that button's index.
  - Simultaneous presses resolve with priority 3 > 2 > 1.
  - No press leaves `speed_sel` unchanged.
- **Divider:** `div_cnt` counts 0..P-1, where P is the period for the current `speed_sel`.
  - At `div_cnt == P-1`: `div_cnt <= 0`, `tick <= 1`, `div_clk <= ~div_clk`.
  - Otherwise: `div_cnt <= div_cnt+1`, `tick <= 0`.
- **Restart:** on any accepted press, including a re-press of the current speed:
  - `div_cnt <= 0` and `tick <= 0` on that edge.
  - A coincident wrap is suppressed and `div_clk` holds.
  - The new P applies from that edge.
- **Widths:** counters are sized for the largest of `P0..P3` and for `DEB_CYCLES`. Wrap is only at P-1, never by overflow.

## Timing
- **Reset values:**
  - `tick = 0`, `div_clk = 0`, `speed_sel = 0`.
  - All sync flops, `deb_n`, `deb_q_n`, `dc_n` and `div_cnt` = 0.
  - Reset has priority over every other event, including mid-debounce and mid-period.
- **Press latency** (raw high and stable before edge 0):
  - `s_n` high after edge 1.
  - `deb_n` high after edge 1+`DEB_CYCLES`.
  - `speed_sel` updated and `div_cnt` = 0 after edge 2+`DEB_CYCLES`.
- **After reset or restart edge R:** `tick` is high in the cycle following edge R+P, then every P cycles.
- **`div_clk` period** is 2P cycles, and it rises on every second tick.
- **`tick`** is never high on two consecutive cycles, because P ≥ 2.
- **Reset deasserted with a button already held:** this counts as a press after the debounce latency.

## Test plan
Bench parameters: `DEB_CYCLES=4`, `P0=8`, `P1=6`, `P2=4`, `P3=2`.

- **Reset then idle 40 cycles:**
  - `speed_sel=0`.
  - `tick` high after edges 8, 16, 24, 32, 40 only.
  - `div_clk` toggles at each of those edges.
- **`speed2` high before edge 10, held:**
  - `speed_sel` becomes 2 after edge 16 and `div_cnt` restarts.
  - Ticks after edges 20, 24, 28, …
- **`speed1` pulsed high for 3 cycles, repeated 5 times with 2-cycle gaps:** `speed_sel` never changes and the tick cadence is undisturbed.
- **`speed1` and `speed3` rising on the same cycle:**
  - `speed_sel=3`.
  - Tick every 2 cycles from the restart edge.
  - Release of either button changes nothing.
- **`speed3` press accepted on the exact edge where `div_cnt == P-1`:** no tick on that edge, `div_clk` holds, and the next tick comes 2 cycles later.
- **`reset` asserted for 1 cycle with `speed_sel=2` and `div_cnt=3`:**
  - Next cycle `tick=0`, `div_clk=0`, `speed_sel=0`.
  - First tick after edge 8 following reset release.
